// File: rtl/arcino_instr_aligner_if.sv
// Bus bundle between prefetch buffer, instruction aligner and decoder.
// slave = aligner view, master = environment (prefetch + decoder) view.
interface arcino_instr_aligner_if;
    localparam int unsigned XLEN = 32;

    logic            branch_i;
    logic [XLEN-1:0] branch_addr_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] in_rdata_i;
    logic [XLEN-1:0] in_addr_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] out_instr_o;
    logic [XLEN-1:0] out_pc_o;
    logic            out_compressed_o;

    modport slave (
        input  branch_i, branch_addr_i, in_valid_i, in_rdata_i, in_addr_i, out_ready_i,
        output in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_compressed_o
    );

    modport master (
        output branch_i, branch_addr_i, in_valid_i, in_rdata_i, in_addr_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_compressed_o
    );
endinterface

// File: rtl/arcino_instr_aligner.sv
// Halfword aligner: splits 32-bit fetch words into RVC / 32-bit instructions,
// holding one upper halfword and its PC across word boundaries.
module arcino_instr_aligner #(
    parameter bit RVC_EN = 1'b1
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    arcino_instr_aligner_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned HW   = 16;

    typedef enum logic [1:0] {
        ALIGNED = 2'd0,
        HALF    = 2'd1,
        SKIP    = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   half_q, half_d;
    logic [XLEN-1:0] half_pc_q, half_pc_d;

    logic [HW-1:0]   lo_c;
    logic            lo_rvc_c;
    logic            half_rvc_c;
    logic            out_hs_c;
    logic [XLEN-1:0] word_pc_c;
    logic            unused_c;

    assign lo_c       = bus.in_rdata_i[HW-1:0];
    assign lo_rvc_c   = RVC_EN && (lo_c[1:0] != 2'b11);
    assign half_rvc_c = RVC_EN && (half_q[1:0] != 2'b11);
    assign word_pc_c  = {bus.in_addr_i[XLEN-1:2], 2'b00};
    assign out_hs_c   = bus.out_valid_o && bus.out_ready_i;
    assign unused_c   = ^{bus.in_addr_i[1:0], bus.branch_addr_i[XLEN-1:2], bus.branch_addr_i[0]};

    // State and held-halfword registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ALIGNED;
            half_q    <= '0;
            half_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            half_pc_q <= half_pc_d;
        end
    end

    // Next state and held-halfword update; branch overrides everything
    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        half_pc_d = half_pc_q;
        if (bus.branch_i) begin
            state_d = (RVC_EN && bus.branch_addr_i[1]) ? SKIP : ALIGNED;
            half_d  = '0;
        end else begin
            unique case (state_q)
                ALIGNED: begin
                    if (out_hs_c && lo_rvc_c) begin
                        half_d    = bus.in_rdata_i[XLEN-1:HW];
                        half_pc_d = word_pc_c + XLEN'(2);
                        state_d   = HALF;
                    end
                end
                HALF: begin
                    if (out_hs_c) begin
                        if (half_rvc_c) begin
                            state_d = ALIGNED;
                        end else begin
                            half_d    = bus.in_rdata_i[XLEN-1:HW];
                            half_pc_d = half_pc_q + XLEN'(4);
                        end
                    end
                end
                SKIP: begin
                    if (bus.in_valid_i) begin
                        half_d    = bus.in_rdata_i[XLEN-1:HW];
                        half_pc_d = {bus.in_addr_i[XLEN-1:2], 2'b10};
                        state_d   = HALF;
                    end
                end
                default: state_d = ALIGNED;
            endcase
        end
    end

    // Combinational handshake and instruction outputs
    always_comb begin
        bus.out_valid_o      = 1'b0;
        bus.in_ready_o       = 1'b0;
        bus.out_instr_o      = '0;
        bus.out_pc_o         = '0;
        bus.out_compressed_o = 1'b0;
        if (!bus.branch_i) begin
            unique case (state_q)
                ALIGNED: begin
                    bus.out_valid_o = bus.in_valid_i;
                    bus.in_ready_o  = bus.out_ready_i;
                    bus.out_pc_o    = word_pc_c;
                    if (lo_rvc_c) begin
                        bus.out_instr_o      = {{HW{1'b0}}, lo_c};
                        bus.out_compressed_o = 1'b1;
                    end else begin
                        bus.out_instr_o = bus.in_rdata_i;
                    end
                end
                HALF: begin
                    bus.out_pc_o = half_pc_q;
                    if (half_rvc_c) begin
                        bus.out_valid_o      = 1'b1;
                        bus.out_instr_o      = {{HW{1'b0}}, half_q};
                        bus.out_compressed_o = 1'b1;
                    end else begin
                        bus.out_valid_o = bus.in_valid_i;
                        bus.in_ready_o  = bus.out_ready_i;
                        bus.out_instr_o = {lo_c, half_q};
                    end
                end
                SKIP: begin
                    bus.in_ready_o = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
